// File: rtl/etroc2_frame_pkg.sv
// etroc2_frame_pkg
// Shared definitions for the ETROC2 frame builder:
//   - header preamble and hit-limit defaults
//   - frame field widths and bit offsets of the header, data and trailer words
//   - trailer status bit indices
//   - FSM state encoding {S_IDLE, S_DATA}
//   - CRC-8 polynomial and a single-bit CRC step helper
package etroc2_frame_pkg;

  localparam logic [15:0] HEADER_PATTERN_DEF = 16'h3C5C;
  localparam int unsigned MAX_HITS_DEF       = 255;

  localparam int FRAME_W = 40;
  localparam int TDC_W   = 29;
  localparam int PIX_W   = 8;
  localparam int BCID_W  = 12;
  localparam int EA_W    = 2;
  localparam int CHIP_W  = 17;
  localparam int CNT_W   = 8;
  localparam int CRC_W   = 8;
  localparam int STAT_W  = 6;

  // Header: {pattern[39:24], 2'b00, l1Counter[21:14], 2'b00, BCID[11:0]}
  localparam int HDR_PAT_LSB  = 24;
  localparam int HDR_L1_LSB   = 14;
  localparam int HDR_BCID_LSB = 0;
  // Data: {1'b1, EA[38:37], col[36:33], row[32:29], TDC[28:0]}
  localparam int DAT_FLAG_BIT = 39;
  localparam int DAT_EA_LSB   = 37;
  localparam int DAT_PIX_LSB  = 29;
  localparam int DAT_TDC_LSB  = 0;
  // Trailer: {1'b0, chipId[38:22], status[21:16], hitCount[15:8], crc[7:0]}
  localparam int TRL_CHIP_LSB = 22;
  localparam int TRL_STAT_LSB = 16;
  localparam int TRL_CNT_LSB  = 8;
  localparam int TRL_CRC_LSB  = 0;
  // The CRC covers only the upper 32 bits of the trailer.
  localparam int TRL_CRC_SPAN = FRAME_W - CRC_W;

  localparam int ST_L1_FULL  = 5;
  localparam int ST_L1_OVF   = 4;
  localparam int ST_L1_HALF  = 3;
  localparam int ST_PROTO    = 2;
  localparam int ST_HIT_SAT  = 1;
  localparam int ST_ANY_EA   = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_t;

  localparam logic [CRC_W-1:0] CRC_POLY = 8'h2F;

  // One MSB-first CRC-8 step (no reflection).
  function automatic logic [CRC_W-1:0] crc8_bit(input logic [CRC_W-1:0] crc, input logic din);
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/etroc2_frame_builder_crc8.sv
// frame_crc8
// Combinational CRC-8 update over a W-bit word, MSB first.
// Ports:
//   i_crc  [7:0]   running CRC before this word
//   i_data [W-1:0] word to fold in
//   o_crc  [7:0]   running CRC after this word
// Only instantiated when FRAME_CRC_EN is defined.
module frame_crc8
  import etroc2_frame_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic [CRC_W-1:0] i_crc,
  input  logic [W-1:0]     i_data,
  output logic [CRC_W-1:0] o_crc
);

  always_comb begin
    o_crc = i_crc;
    for (int i = W - 1; i >= 0; i--) begin
      o_crc = crc8_bit(o_crc, i_data[i]);
    end
  end

endmodule

// File: rtl/etroc2_frame_builder.sv
// etroc2_frame_builder
// Turns the readout controller event stream into 40-bit ETROC2 frames:
// one header, zero or more data words, one trailer per event.
// At most one word per clock; no backpressure.
// Ports:
//   clk, reset (async, active-low)
//   eventStart, hit, inTDCData[28:0], inPixelID[7:0], inBCID[11:0], inEA[1:0]
//   inL1BufFull, inL1BufOverflow, inL1BufHalfFull, chipId[16:0]
//   dout[39:0], doutValid, l1Counter[7:0], protoErr (sticky)
// Build option: FRAME_CRC_EN adds a running CRC-8 in the trailer;
// without it the trailer CRC field is 8'h00 and no CRC logic exists.
//
// state  | meaning
// S_IDLE | waiting for eventStart; stray hits ignored
// S_DATA | header sent; emitting data words until hit=0 (or eventStart)
module etroc2_frame_builder
  import etroc2_frame_pkg::*;
#(
  parameter logic [15:0] HEADER_PATTERN = HEADER_PATTERN_DEF,
  parameter int unsigned MAX_HITS       = MAX_HITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               eventStart,
  input  logic               hit,
  input  logic [TDC_W-1:0]   inTDCData,
  input  logic [PIX_W-1:0]   inPixelID,
  input  logic [BCID_W-1:0]  inBCID,
  input  logic [EA_W-1:0]    inEA,
  input  logic               inL1BufFull,
  input  logic               inL1BufOverflow,
  input  logic               inL1BufHalfFull,
  input  logic [CHIP_W-1:0]  chipId,
  output logic [FRAME_W-1:0] dout,
  output logic               doutValid,
  output logic [CNT_W-1:0]   l1Counter,
  output logic               protoErr
);

  localparam logic [CNT_W-1:0] LP_MAX_HITS = MAX_HITS[CNT_W-1:0];

  state_t             r_state, w_state_nxt;
  logic [FRAME_W-1:0] r_dout, w_word;
  logic               r_valid, w_valid;
  logic [CNT_W-1:0]   r_l1_cnt, w_l1_cnt_nxt;
  logic [CNT_W-1:0]   r_hit_cnt, w_hit_cnt_nxt;
  logic               r_hit_sat, w_hit_sat_nxt;
  logic               r_any_ea, w_any_ea_nxt;
  logic [2:0]         r_l1_flags, w_l1_flags_nxt;
  logic               r_proto_err, w_proto_err_nxt;

  logic [FRAME_W-1:0]      w_header, w_data, w_trailer;
  logic [TRL_CRC_SPAN-1:0] w_trl_hi;
  logic [CRC_W-1:0]        w_crc_trl;

  assign w_header = {HEADER_PATTERN, 2'b00, r_l1_cnt, 2'b00, inBCID};
  assign w_data   = {1'b1, inEA, inPixelID[7:4], inPixelID[3:0], inTDCData};
  // eventStart here can only be set on the protocol-error trailer.
  assign w_trl_hi  = {1'b0, chipId, r_l1_flags, eventStart, r_hit_sat, r_any_ea, r_hit_cnt};
  assign w_trailer = {w_trl_hi, w_crc_trl};

  always_comb begin
    w_state_nxt     = r_state;
    w_valid         = 1'b0;
    w_word          = '0;
    w_l1_cnt_nxt    = r_l1_cnt;
    w_hit_cnt_nxt   = r_hit_cnt;
    w_hit_sat_nxt   = r_hit_sat;
    w_any_ea_nxt    = r_any_ea;
    w_l1_flags_nxt  = r_l1_flags;
    w_proto_err_nxt = r_proto_err;
    case (r_state)
      S_IDLE: begin
        if (eventStart) begin
          w_valid        = 1'b1;
          w_word         = w_header;
          w_l1_cnt_nxt   = r_l1_cnt + 8'd1;
          w_l1_flags_nxt = {inL1BufFull, inL1BufOverflow, inL1BufHalfFull};
          w_hit_cnt_nxt  = '0;
          w_hit_sat_nxt  = 1'b0;
          w_any_ea_nxt   = 1'b0;
          w_state_nxt    = S_DATA;
        end
      end
      S_DATA: begin
        if (eventStart) begin
          // Overlapping event: close this one, count and drop the new one.
          w_valid         = 1'b1;
          w_word          = w_trailer;
          w_proto_err_nxt = 1'b1;
          w_l1_cnt_nxt    = r_l1_cnt + 8'd1;
          w_state_nxt     = S_IDLE;
        end else if (hit) begin
          if (r_hit_cnt < LP_MAX_HITS) begin
            w_valid       = 1'b1;
            w_word        = w_data;
            w_hit_cnt_nxt = r_hit_cnt + 8'd1;
            w_any_ea_nxt  = r_any_ea | (|inEA);
          end else begin
            w_hit_sat_nxt = 1'b1;
          end
        end else begin
          w_valid     = 1'b1;
          w_word      = w_trailer;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_l1_cnt    <= '0;
      r_hit_cnt   <= '0;
      r_hit_sat   <= 1'b0;
      r_any_ea    <= 1'b0;
      r_l1_flags  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dout      <= w_word;
      r_valid     <= w_valid;
      r_l1_cnt    <= w_l1_cnt_nxt;
      r_hit_cnt   <= w_hit_cnt_nxt;
      r_hit_sat   <= w_hit_sat_nxt;
      r_any_ea    <= w_any_ea_nxt;
      r_l1_flags  <= w_l1_flags_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

`ifdef FRAME_CRC_EN
  logic [CRC_W-1:0]   r_crc, w_crc_seed, w_crc_word;
  logic [FRAME_W-1:0] w_crc_in;

  // Only a header can be emitted from IDLE, and it restarts the CRC.
  assign w_crc_seed = (r_state == S_IDLE) ? '0 : r_crc;
  assign w_crc_in   = (r_state == S_IDLE) ? w_header : w_data;

  frame_crc8 #(.W(FRAME_W)) u_crc_word (
    .i_crc  (w_crc_seed),
    .i_data (w_crc_in),
    .o_crc  (w_crc_word)
  );

  frame_crc8 #(.W(TRL_CRC_SPAN)) u_crc_trl (
    .i_crc  (r_crc),
    .i_data (w_trl_hi),
    .o_crc  (w_crc_trl)
  );

  // Words that leave us in DATA are header or data words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_crc <= '0;
    end else if (w_valid && (w_state_nxt == S_DATA)) begin
      r_crc <= w_crc_word;
    end
  end
`else
  assign w_crc_trl = '0;
`endif

  assign dout      = r_dout;
  assign doutValid = r_valid;
  assign l1Counter = r_l1_cnt;
  assign protoErr  = r_proto_err;

endmodule

// File: tb/tb_etroc2_frame_builder.sv
module tb_etroc2_frame_builder;

  logic        clk = 1'b0;
  logic        reset;
  logic        eventStart, hit;
  logic [28:0] inTDCData;
  logic [7:0]  inPixelID;
  logic [11:0] inBCID;
  logic [1:0]  inEA;
  logic        inL1BufFull, inL1BufOverflow, inL1BufHalfFull;
  logic [16:0] chipId;
  logic [39:0] dout;
  logic        doutValid;
  logic [7:0]  l1Counter;
  logic        protoErr;

  int n_checks = 0;
  int n_err    = 0;

  etroc2_frame_builder dut (
    .clk             (clk),
    .reset           (reset),
    .eventStart      (eventStart),
    .hit             (hit),
    .inTDCData       (inTDCData),
    .inPixelID       (inPixelID),
    .inBCID          (inBCID),
    .inEA            (inEA),
    .inL1BufFull     (inL1BufFull),
    .inL1BufOverflow (inL1BufOverflow),
    .inL1BufHalfFull (inL1BufHalfFull),
    .chipId          (chipId),
    .dout            (dout),
    .doutValid       (doutValid),
    .l1Counter       (l1Counter),
    .protoErr        (protoErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        es;
    logic        hit;
    logic [28:0] tdc;
    logic [7:0]  pix;
    logic [11:0] bcid;
    logic [1:0]  ea;
    logic [2:0]  l1f;
    logic [16:0] chip;
    logic        exp_v;
    logic [39:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic es, input logic h, input logic [28:0] tdc, input logic [7:0] pix,
                     input logic [11:0] bcid, input logic [1:0] ea, input logic [2:0] l1f);
    eventStart      = es;
    hit             = h;
    inTDCData       = tdc;
    inPixelID       = pix;
    inBCID          = bcid;
    inEA            = ea;
    inL1BufFull     = l1f[2];
    inL1BufOverflow = l1f[1];
    inL1BufHalfFull = l1f[0];
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 29'd0, 8'd0, 12'd0, 2'd0, 3'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference frame formats, built from the field definitions.
  function automatic logic [39:0] mk_hdr(input logic [7:0] l1, input logic [11:0] bcid);
    return {16'h3C5C, 2'b00, l1, 2'b00, bcid};
  endfunction

  function automatic logic [39:0] mk_dat(input logic [1:0] ea, input logic [7:0] pix, input logic [28:0] tdc);
    return {1'b1, ea, pix, tdc};
  endfunction

  function automatic logic [39:0] mk_trl(input logic [16:0] chip, input logic [2:0] l1f, input logic pe,
                                         input logic sat, input logic aea, input logic [7:0] cnt);
    return {1'b0, chip, l1f, pe, sat, aea, cnt, 8'h00};
  endfunction

  logic [7:0]  exp_l1;
  logic        exp_proto;
  logic [31:0] r32, r32b;
  int          nwords;

  initial begin
    reset = 1'b0;
    chipId = 17'h0ABCD;
    idle();
    #23;
    chk("rst_dout",   64'(dout), 64'd0);
    chk("rst_valid",  64'(doutValid), 64'd0);
    chk("rst_l1",     64'(l1Counter), 64'd0);
    chk("rst_proto",  64'(protoErr), 64'd0);
    reset = 1'b1;
    cyc();

    // ---------------- table-driven vectors ----------------
    vecs.push_back('{"basic_hdr",  1'b1, 1'b0, 29'd0, 8'h00, 12'h123, 2'd0, 3'b000, 17'h0ABCD, 1'b1, 40'h3C5C000123});
    vecs.push_back('{"basic_d0",   1'b0, 1'b1, 29'd0, 8'h5A, 12'h000, 2'd0, 3'b000, 17'h0ABCD, 1'b1, 40'h8B40000000});
    vecs.push_back('{"basic_d1",   1'b0, 1'b1, 29'd0, 8'h5A, 12'h000, 2'd0, 3'b000, 17'h0ABCD, 1'b1, 40'h8B40000000});
    vecs.push_back('{"basic_trl",  1'b0, 1'b0, 29'd0, 8'h00, 12'h000, 2'd0, 3'b000, 17'h0ABCD, 1'b1, 40'h2AF3400200});
    vecs.push_back('{"gap_idle",   1'b0, 1'b1, 29'd7, 8'h11, 12'h000, 2'd3, 3'b000, 17'h00000, 1'b0, 40'h0});
    vecs.push_back('{"ovf_hdr",    1'b1, 1'b0, 29'd0, 8'h00, 12'h456, 2'd0, 3'b010, 17'h00000, 1'b1, 40'h3C5C004456});
    vecs.push_back('{"ovf_trl",    1'b0, 1'b0, 29'd0, 8'h00, 12'h000, 2'd0, 3'b000, 17'h00000, 1'b1, 40'h0000100000});
    vecs.push_back('{"after_idle", 1'b0, 1'b0, 29'd0, 8'h00, 12'h000, 2'd0, 3'b000, 17'h00000, 1'b0, 40'h0});
    foreach (vecs[i]) begin
      drv(vecs[i].es, vecs[i].hit, vecs[i].tdc, vecs[i].pix, vecs[i].bcid, vecs[i].ea, vecs[i].l1f);
      chipId = vecs[i].chip;
      cyc();
      chk({vecs[i].name, "_v"}, 64'(doutValid), 64'(vecs[i].exp_v));
      if (vecs[i].exp_v) chk(vecs[i].name, 64'(dout), 64'(vecs[i].exp_d));
    end
    chk("tbl_l1", 64'(l1Counter), 64'd2);

    // ---------------- 257 zero-hit events from reset ----------------
    reset = 1'b0;
    #3;
    chk("rst2_l1", 64'(l1Counter), 64'd0);
    reset = 1'b1;
    cyc();
    for (int e = 0; e < 257; e++) begin
      drv(1'b1, 1'b0, 29'd0, 8'd0, 12'hABC, 2'd0, 3'd0);
      cyc();
      chk("wrap_hdr", 64'(dout), 64'(mk_hdr(8'(e % 256), 12'hABC)));
      idle();
      cyc();
      chk("wrap_trl", 64'({doutValid, dout}), 64'({1'b1, mk_trl(17'h00000, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0)}));
    end
    chk("wrap_l1_end", 64'(l1Counter), 64'h01);

    // ---------------- eventStart while in DATA ----------------
    chipId = 17'h1F00F;
    drv(1'b1, 1'b0, 29'd0, 8'd0, 12'h321, 2'd0, 3'b101);
    cyc();
    chk("pe_hdr", 64'(dout), 64'(mk_hdr(8'h01, 12'h321)));
    drv(1'b0, 1'b1, 29'h1234567, 8'hC3, 12'd0, 2'd0, 3'd0);
    cyc();
    chk("pe_dat", 64'(dout), 64'(mk_dat(2'd0, 8'hC3, 29'h1234567)));
    drv(1'b1, 1'b0, 29'd0, 8'd0, 12'h999, 2'd0, 3'b010);
    cyc();
    chk("pe_trl", 64'({doutValid, dout}), 64'({1'b1, mk_trl(17'h1F00F, 3'b101, 1'b1, 1'b0, 1'b0, 8'd1)}));
    chk("pe_bit18", 64'(dout[18]), 64'd1);
    chk("pe_flag", 64'(protoErr), 64'd1);
    chk("pe_l1", 64'(l1Counter), 64'h03);
    drv(1'b0, 1'b1, 29'd5, 8'h22, 12'd0, 2'd1, 3'd0);
    cyc();
    chk("pe_idle_next", 64'(doutValid), 64'd0);
    idle();
    cyc();
    cyc();
    chk("pe_sticky", 64'(protoErr), 64'd1);

    // ---------------- 300 consecutive hits ----------------
    drv(1'b1, 1'b0, 29'd0, 8'd0, 12'h055, 2'd0, 3'd0);
    cyc();
    chk("sat_hdr", 64'(dout), 64'(mk_hdr(8'h03, 12'h055)));
    nwords = 0;
    for (int h = 0; h < 300; h++) begin
      drv(1'b0, 1'b1, 29'(h), 8'(h), 12'd0, 2'd0, 3'd0);
      cyc();
      if (doutValid) nwords++;
    end
    chk("sat_words", 64'(nwords), 64'd255);
    idle();
    cyc();
    chk("sat_trl", 64'({doutValid, dout}), 64'({1'b1, mk_trl(17'h1F00F, 3'd0, 1'b0, 1'b1, 1'b0, 8'hFF)}));
    exp_l1 = 8'h04;
    exp_proto = 1'b1;

    // ---------------- randomized events vs event-level model ----------------
    for (int e = 0; e < 40; e++) begin
      logic [2:0]  l1f_cap;
      logic [7:0]  cnt;
      logic        aea;
      int          nh;
      bit          abort;
      r32 = $urandom;
      chipId = r32[16:0];
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        r32 = $urandom;
        drv(1'b0, r32[0], r32[28:0], r32[15:8], 12'd0, r32[2:1], r32[5:3]);
        cyc();
        chk("rnd_gap", 64'(doutValid), 64'd0);
      end
      r32 = $urandom;
      l1f_cap = r32[14:12];
      drv(1'b1, r32[0], 29'd0, 8'd0, r32[27:16], 2'd0, l1f_cap);
      cyc();
      chk("rnd_hdr", 64'({doutValid, dout}), 64'({1'b1, mk_hdr(exp_l1, r32[27:16])}));
      exp_l1 = exp_l1 + 8'd1;
      nh = int'($urandom_range(0, 5));
      abort = ($urandom_range(0, 5) == 0);
      cnt = 8'd0;
      aea = 1'b0;
      for (int h = 0; h < nh; h++) begin
        r32 = $urandom;
        r32b = $urandom;
        drv(1'b0, 1'b1, r32[28:0], r32b[7:0], r32b[19:8], r32b[31:30], r32b[22:20]);
        cyc();
        chk("rnd_dat", 64'({doutValid, dout}), 64'({1'b1, mk_dat(r32b[31:30], r32b[7:0], r32[28:0])}));
        cnt = cnt + 8'd1;
        aea = aea | (|r32b[31:30]);
      end
      r32 = $urandom;
      drv(abort, abort & r32[0], r32[28:0], 8'd0, r32[11:0], 2'd0, r32[31:29]);
      cyc();
      chk("rnd_trl", 64'({doutValid, dout}), 64'({1'b1, mk_trl(chipId, l1f_cap, abort, 1'b0, aea, cnt)}));
      if (abort) begin
        exp_l1 = exp_l1 + 8'd1;
        exp_proto = 1'b1;
      end
      chk("rnd_l1", 64'(l1Counter), 64'(exp_l1));
      chk("rnd_proto", 64'(protoErr), 64'(exp_proto));
    end

    // ---------------- reset in the middle of an event ----------------
    chipId = 17'h00001;
    drv(1'b1, 1'b0, 29'd0, 8'd0, 12'h0F0, 2'd0, 3'd0);
    cyc();
    for (int h = 0; h < 3; h++) begin
      drv(1'b0, 1'b1, 29'(h + 1), 8'h77, 12'd0, 2'd2, 3'd0);
      cyc();
      chk("mr_dat", 64'({doutValid, dout}), 64'({1'b1, mk_dat(2'd2, 8'h77, 29'(h + 1))}));
    end
    #2;
    reset = 1'b0;
    #1;
    chk("mr_valid", 64'(doutValid), 64'd0);
    chk("mr_l1", 64'(l1Counter), 64'd0);
    chk("mr_proto", 64'(protoErr), 64'd0);
    cyc();
    chk("mr_no_trl", 64'(doutValid), 64'd0);
    #2;
    reset = 1'b1;
    drv(1'b1, 1'b0, 29'd0, 8'd0, 12'h0AA, 2'd0, 3'd0);
    cyc();
    chk("mr_hdr", 64'({doutValid, dout}), 64'({1'b1, mk_hdr(8'h00, 12'h0AA)}));
    idle();
    cyc();
    chk("mr_trl", 64'({doutValid, dout}), 64'({1'b1, mk_trl(17'h00001, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0)}));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
